aes_key_mem: RTL

- Key expansion and round-key storage for the AES datapath.
- On `init`, expands a 128-bit or 256-bit cipher key into 11 or 15 round keys at one key per cycle, and stores them in an internal register file.
- Serves the round key combinationally to the encipher round logic via `round` → `round_key`.
- Borrows the shared 4-byte S-box through `sboxw`/`new_sboxw` while expanding.

---
 rtl/aes_key_mem_if.sv | 23 ++
 rtl/aes_key_mem.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/aes_key_mem_if.sv
// Key-memory bus: cipher key / start pulse in, round-key read port, shared S-box borrow.
// No latency of its own; the read port is combinational.
// No backpressure; consumers wait for ready before reading.
interface aes_key_mem_if;
    logic [255:0] key;
    logic         keylen;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    modport master (
        output key, keylen, init, round, new_sboxw,
        input  round_key, ready, sboxw
    );

    modport slave (
        input  key, keylen, init, round, new_sboxw,
        output round_key, ready, sboxw
    );
endinterface

// File: rtl/aes_key_mem.sv
// AES key expansion into a round-key table; AES-256 support under AES_KEY_MEM_AES256_EN.
// Latency: init at E0, keys written E1..E11 (E1..E15 for AES-256), ready rises one edge later.
// No backpressure: init restarts at any time, reads are combinational and valid once ready=1.
module aes_key_mem #(
    parameter int NUM_KEYS_MAX = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    aes_key_mem_if.slave  bus
);

`ifdef AES_KEY_MEM_AES256_EN
    localparam int NUM_KEYS = NUM_KEYS_MAX;
`else
    localparam int NUM_KEYS = NUM_KEYS_MAX - 4;
`endif
    localparam logic [3:0] NUM_KEYS_W = 4'(NUM_KEYS);

    typedef enum logic [1:0] {IDLE, GENERATE, DONE} state_t;

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic [3:0]    ctr_q, ctr_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [127:0]  prev_q, prev_d;
    logic [127:0]  key_mem_q [NUM_KEYS];
    logic [127:0]  key_mem_d [NUM_KEYS];
`ifdef AES_KEY_MEM_AES256_EN
    logic          keylen_q, keylen_d;
    logic [255:0]  key_q, key_d;
    logic [127:0]  pp_q, pp_d;
`else
    logic [127:0]  key_q, key_d;
    logic          unused_in;
    assign unused_in = ^{bus.keylen, bus.key[127:0]};
`endif

    logic [3:0]    last;
    logic [127:0]  base;
    logic [127:0]  new_key;
    logic [31:0]   t, w0, w1, w2, w3;
    logic [7:0]    rcon_nx;
    logic          rcon_adv;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Next round key from the shared S-box result and the previous key(s).
    always_comb begin
        rcon_nx  = gm2(rcon_q);
        base     = prev_q;
        t        = {bus.new_sboxw[23:0], bus.new_sboxw[31:24]} ^ {rcon_nx, 24'h0};
        rcon_adv = 1'b1;
        last     = 4'd10;
`ifdef AES_KEY_MEM_AES256_EN
        if (keylen_q) begin
            last = 4'd14;
            if (ctr_q >= 4'd2) base = pp_q;
            if (ctr_q[0]) begin
                t        = bus.new_sboxw;
                rcon_adv = 1'b0;
            end
        end
`endif
        w0      = base[127:96] ^ t;
        w1      = base[95:64]  ^ w0;
        w2      = base[63:32]  ^ w1;
        w3      = base[31:0]   ^ w2;
        new_key = {w0, w1, w2, w3};
        if (ctr_q == 4'd0) begin
            new_key  = key_q[$bits(key_q)-1 -: 128];
            rcon_adv = 1'b0;
        end
`ifdef AES_KEY_MEM_AES256_EN
        if (keylen_q && ctr_q == 4'd1) new_key = key_q[127:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        ctr_d     = ctr_q;
        rcon_d    = rcon_q;
        prev_d    = prev_q;
        key_mem_d = key_mem_q;
        key_d     = key_q;
`ifdef AES_KEY_MEM_AES256_EN
        keylen_d  = keylen_q;
        pp_d      = pp_q;
`endif
        // init wins in every state, so a restart behaves exactly like a fresh start.
        if (bus.init) begin
            state_d  = GENERATE;
            ready_d  = 1'b0;
            ctr_d    = 4'd0;
            rcon_d   = 8'h8d;
`ifdef AES_KEY_MEM_AES256_EN
            key_d    = bus.key;
            keylen_d = bus.keylen;
`else
            key_d    = bus.key[255:128];
`endif
        end else begin
            case (state_q)
                GENERATE: begin
                    key_mem_d[ctr_q] = new_key;
                    prev_d           = new_key;
`ifdef AES_KEY_MEM_AES256_EN
                    pp_d             = prev_q;
`endif
                    if (rcon_adv) rcon_d = rcon_nx;
                    ctr_d = ctr_q + 4'd1;
                    if (ctr_q == last) state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            ctr_q    <= 4'd0;
            rcon_q   <= 8'h8d;
            prev_q   <= '0;
            key_q    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) key_mem_q[i] <= '0;
`ifdef AES_KEY_MEM_AES256_EN
            keylen_q <= 1'b0;
            pp_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ctr_q     <= ctr_d;
            rcon_q    <= rcon_d;
            prev_q    <= prev_d;
            key_q     <= key_d;
            key_mem_q <= key_mem_d;
`ifdef AES_KEY_MEM_AES256_EN
            keylen_q  <= keylen_d;
            pp_q      <= pp_d;
`endif
        end
    end

    assign bus.round_key = (bus.round < NUM_KEYS_W) ? key_mem_q[bus.round] : 128'h0;
    assign bus.sboxw     = (state_q == GENERATE) ? prev_q[31:0] : 32'h0;
    assign bus.ready     = ready_q;

endmodule
